// File: rtl/arb_pkg.sv
// Shared definitions for the priority arbiter: FSM state encoding and
// arbitration mode selectors.
package arb_pkg;

    // Raw state codes, kept visible so checkers can compare against dbg_state
    localparam logic ST_IDLE  = 1'b0;
    localparam logic ST_GRANT = 1'b1;

    // Arbitration policy selectors for the MODE parameter
    localparam int MODE_FIXED = 0;
    localparam int MODE_RR    = 1;

    typedef enum logic {
        S_IDLE  = ST_IDLE,
        S_GRANT = ST_GRANT
    } arb_state_e;

endpackage

// File: rtl/priority_pick.sv
// Combinational wrap-around priority search. Starting at index 'start' and
// moving downward (start, start-1, ..., 0, N-1, ...), report the first set
// request bit. With start = N-1 this is a plain highest-index-wins encoder.
module priority_pick #(
    parameter int N    = 8,
    parameter int IDXW = $clog2(N)
) (
    input  logic [N-1:0]    req,
    input  logic [IDXW-1:0] start,
    output logic            found,
    output logic [IDXW-1:0] idx
);

    logic [IDXW-1:0] pos;

    // Walk the N candidate positions in priority order; the first hit wins
    always_comb begin
        found = 1'b0;
        idx   = '0;
        pos   = '0;
        for (int k = 0; k < N; k++) begin
            // Positions below zero wrap to the top of the vector. Using
            // start + (N - k) keeps the wrap correct for non power-of-two N.
            if (IDXW'(k) > start) begin
                pos = start + IDXW'(N - k);
            end else begin
                pos = start - IDXW'(k);
            end
            if (!found && req[pos]) begin
                found = 1'b1;
                idx   = pos;
            end
        end
    end

endmodule

// File: rtl/priority_arbiter.sv
// Registered N-way arbiter. A grant, once issued, is held until the holder
// pulses done or drops its request; there is always one idle cycle between
// grants. MODE selects fixed priority (highest index wins) or round-robin
// (the previous holder gets the lowest priority on the next search).
//
// Handshake: req[i] is a level request; gnt/gnt_idx/gnt_valid are registered
// and appear one clock after the winning request is seen in IDLE. The grant
// is released on the first edge where done is high or req[gnt_idx] is low.
// done outside a grant has no effect. dbg_state and dbg_last expose the FSM
// state and the round-robin pointer for observation.
module priority_arbiter
    import arb_pkg::*;
#(
    parameter int N    = 8,
    parameter int MODE = MODE_FIXED,
    parameter int IDXW = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N-1:0]    req,
    input  logic            done,
    output logic [N-1:0]    gnt,
    output logic [IDXW-1:0] gnt_idx,
    output logic            gnt_valid,
    output logic            any_req,
    output logic            dbg_state,
    output logic [IDXW-1:0] dbg_last
);

    localparam logic [IDXW-1:0] TOP_IDX = IDXW'(N - 1);

    arb_state_e      state;
    logic [IDXW-1:0] last;
    logic [IDXW-1:0] start;
    logic            pick_found;
    logic [IDXW-1:0] pick_idx;
    logic [N-1:0]    pick_oh;
    logic            release_now;

    assign any_req     = |req;
    assign pick_oh     = N'(1) << pick_idx;
    assign release_now = done | ~req[gnt_idx];
    assign dbg_state   = state;
    assign dbg_last    = last;

    // Search start: fixed mode always scans from the top; round-robin starts
    // just below the previous holder so that holder is considered last.
    always_comb begin
        start = TOP_IDX;
        if (MODE == MODE_RR) begin
            start = (last == '0) ? TOP_IDX : (last - IDXW'(1));
        end
    end

    priority_pick #(
        .N    (N),
        .IDXW (IDXW)
    ) u_pick (
        .req   (req),
        .start (start),
        .found (pick_found),
        .idx   (pick_idx)
    );

    // Grant FSM with registered outputs and the round-robin pointer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            gnt       <= '0;
            gnt_idx   <= '0;
            gnt_valid <= 1'b0;
            last      <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (pick_found) begin
                        gnt       <= pick_oh;
                        gnt_idx   <= pick_idx;
                        gnt_valid <= 1'b1;
                        state     <= S_GRANT;
                    end
                end
                S_GRANT: begin
                    // Grant is frozen; new requests never pre-empt it
                    if (release_now) begin
                        gnt       <= '0;
                        gnt_idx   <= '0;
                        gnt_valid <= 1'b0;
                        last      <= gnt_idx;
                        state     <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Grant integrity: never multi-hot, valid mirrors a non-zero grant, and
    // the index always points at the asserted grant bit.
    a_gnt_onehot: assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0(gnt));
    a_gnt_valid: assert property (@(posedge clk) disable iff (!rst_n)
        gnt_valid == (gnt != '0));
    a_gnt_idx: assert property (@(posedge clk) disable iff (!rst_n)
        gnt_valid |-> gnt[gnt_idx]);

endmodule

// File: doc/priority_arbiter.md
Name: priority_arbiter

Overview:
- Parametrised, registered successor to the 4-bit priority encoder.
- Arbitrates N request lines and produces a one-hot grant plus a binary grant index.
- Holds each grant until the requester releases it.
- Supports fixed-priority mode (highest index wins) and round-robin mode. Sits in front of any shared resource with several requesting channels.

Parameters:
- N, 8, number of request channels; legal range 2..32.
- MODE, 0, 0 = fixed priority (req[N-1] highest), 1 = round-robin.
- IDXW, $clog2(N), width of the grant index; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- req  input  N  request vector; bit i high = channel i requests
- done  input  1  single-cycle pulse from the current holder: release grant
- gnt  output  N  one-hot grant, registered; all zero when no grant
- gnt_idx  output  IDXW  binary index of the granted channel, registered; 0 when no grant
- gnt_valid  output  1  high while a grant is held, registered
- any_req  output  1  combinational OR of req (encoder "z" equivalent)

Behaviour:
- Reset (rst_n low, asynchronous):
  - gnt = 0, gnt_idx = 0, gnt_valid = 0.
  - state = IDLE, rr pointer last = 0.
- States: IDLE, GRANT.
- IDLE, any_req = 1:
  - Pick the winner.
  - At the next clk edge: gnt = one-hot(winner), gnt_idx = winner, gnt_valid = 1, state = GRANT.
  - Latency is 1 cycle from req to grant.
- IDLE, any_req = 0: all outputs stay 0.
- GRANT:
  - The grant is frozen. New or higher-priority requests never pre-empt it.
  - Release condition: done = 1, or req[gnt_idx] = 0. Either condition alone releases.
  - On release at the next edge: gnt = 0, gnt_valid = 0, state = IDLE, last = gnt_idx.
  - After a release there is always exactly one idle cycle (gnt_valid low) before the next grant.
- Fixed mode winner: the highest set index of req.
- Round-robin mode winner: search downward from (last-1) mod N, wrapping from 0 to N-1, and take the first set bit.
  - The last holder has the lowest priority.
  - After reset the search starts at N-1, so the first grant matches fixed mode.
- last updates only on release. In fixed mode it is maintained but unused.
- done asserted in IDLE is ignored.
- gnt_idx always equals the encoded gnt. gnt is never multi-hot.
- Reset asserted mid-grant: all outputs clear immediately, without waiting for clk.

Decomposition:
- Shared package arb_pkg holds:
  - state encoding localparams: ST_IDLE = 1'b0, ST_GRANT = 1'b1
  - mode constants: MODE_FIXED = 0, MODE_RR = 1
- One sub-module, priority_pick: combinational, parametrised by N.
  - Inputs: req, start index.
  - Outputs: found, index of the first set bit scanning downward from start with wrap.
  - Fixed mode ties start to N-1.
- The arbiter adds the FSM, the output registers and the pointer.

Test Plan (N = 4 unless noted):
- Reset: hold rst_n = 0 with req = 4'b1111 -> gnt = 0, gnt_idx = 0, gnt_valid = 0. Release reset -> one cycle later gnt = 4'b1000, gnt_idx = 3.
- Fixed priority: MODE = 0, req = 4'b0110 -> gnt = 4'b0100, gnt_idx = 2. Raise req[3] while held -> no change. Pulse done -> one idle cycle, then gnt = 4'b1000.
- Round-robin fairness: MODE = 1, req held at 4'b1111, pulse done each time gnt_valid is high -> gnt_idx sequence 3, 2, 1, 0, 3, each grant separated by one idle cycle.
- Release by drop: a grant is held on channel 1 and req[1] goes to 0 with no done -> gnt_valid = 0 next cycle, and last = 1.
- Empty and spurious done: req = 0, done pulsed in IDLE -> outputs stay 0, any_req = 0, state stays IDLE.
- Width sweep: N = 32, MODE = 0, req = 32'h0001_0001 -> gnt_idx = 16, gnt = 32'h0001_0000. Assert rst_n low mid-grant -> outputs clear asynchronously.
